// File: rtl/rst_n_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// the counter width needed to cover both the hold and the timeout intervals.
package rst_n_seq_pkg;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } seq_state_t;

    // One spare bit above the larger interval so the counter can never wrap.
    function automatic int cnt_width(input int hold_cycles, input int timeout_cycles);
        int longest;
        longest = (hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/rst_n_sequencer.sv
// Releases downstream stage resets one at a time in ascending order, holding each
// for HOLD_CYCLES and waiting for its init-done ack, with timeout and software restart.
module rst_n_sequencer
    import rst_n_seq_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int AW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  async_rst_n,
    input  logic                  sw_rst_req,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic [AW-1:0]         active_stage,
    output logic                  seq_done,
    output logic                  timeout_err
);

    localparam int CW = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] LAST_STAGE = AW'(NUM_STAGES - 1);

    if (NUM_STAGES < 1) begin : g_bad_num_stages
        $error("rst_n_sequencer: NUM_STAGES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("rst_n_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("rst_n_sequencer: TIMEOUT_CYCLES must be >= 2");
    end

    seq_state_t            state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [NUM_STAGES-1:0] rst_nxt;
    logic [AW-1:0]         act_nxt;
    logic                  done_nxt;
    logic                  err_nxt;
    logic                  ack;

    assign ack = stage_done[active_stage];

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state        <= S_HOLD;
            cnt          <= '0;
            stage_rst_n  <= '0;
            active_stage <= '0;
            seq_done     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            stage_rst_n  <= rst_nxt;
            active_stage <= act_nxt;
            seq_done     <= done_nxt;
            timeout_err  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_WAIT: begin
                if (ack) begin
                    state_nxt = (active_stage == LAST_STAGE) ? S_DONE : S_HOLD;
                    cnt_nxt   = '0;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = S_ERR;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: ;
        endcase
        // A restart request overrides any release, ack or timeout in the same cycle.
        if (sw_rst_req) begin
            state_nxt = S_HOLD;
            cnt_nxt   = '0;
        end
    end

    always_comb begin
        rst_nxt  = stage_rst_n;
        act_nxt  = active_stage;
        done_nxt = seq_done;
        err_nxt  = timeout_err;
        case (state)
            S_HOLD: begin
                if (cnt == HOLD_LAST) rst_nxt[active_stage] = 1'b1;
            end
            S_WAIT: begin
                if (ack) begin
                    if (active_stage == LAST_STAGE) done_nxt = 1'b1;
                    else                            act_nxt  = active_stage + AW'(1);
                end else if (cnt == TMO_LAST) begin
                    err_nxt = 1'b1;
                    rst_nxt = '0;
                end
            end
            S_DONE: begin
                rst_nxt  = '1;
                done_nxt = 1'b1;
            end
            S_ERR: begin
                rst_nxt  = '0;
                err_nxt  = 1'b1;
                done_nxt = 1'b0;
            end
            default: ;
        endcase
        if (sw_rst_req) begin
            rst_nxt  = '0;
            act_nxt  = '0;
            done_nxt = 1'b0;
            err_nxt  = 1'b0;
        end
    end

endmodule

// File: tb/tb_rst_n_sequencer.sv
// Directed bench for rst_n_sequencer: a default-parameter instance and a short
// HOLD=4/TIMEOUT=8 instance, checked edge by edge against a queue of expected vectors.
module tb_rst_n_sequencer;

    logic       clk;
    logic       rst_a_n, req_a;
    logic [3:0] done_a;
    logic [3:0] a_rst;
    logic [1:0] a_act;
    logic       a_seq, a_err;

    logic       rst_b_n, req_b;
    logic [3:0] done_b;
    logic [3:0] b_rst;
    logic [1:0] b_act;
    logic       b_seq, b_err;

    // Observed vector layout: {stage_rst_n[3:0], active_stage[1:0], seq_done, timeout_err}
    logic [7:0] obs_a, obs_b;
    assign obs_a = {a_rst, a_act, a_seq, a_err};
    assign obs_b = {b_rst, b_act, b_seq, b_err};

    logic [7:0] exp_q[$];
    int n_vec;
    int n_fail;

    rst_n_sequencer dut_a (
        .clk         (clk),
        .async_rst_n (rst_a_n),
        .sw_rst_req  (req_a),
        .stage_done  (done_a),
        .stage_rst_n (a_rst),
        .active_stage(a_act),
        .seq_done    (a_seq),
        .timeout_err (a_err)
    );

    rst_n_sequencer #(
        .NUM_STAGES    (4),
        .HOLD_CYCLES   (4),
        .TIMEOUT_CYCLES(8)
    ) dut_b (
        .clk         (clk),
        .async_rst_n (rst_b_n),
        .sw_rst_req  (req_b),
        .stage_done  (done_b),
        .stage_rst_n (b_rst),
        .active_stage(b_act),
        .seq_done    (b_seq),
        .timeout_err (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Defaults with all acks high: releases at edges 16, 33, 50, 67; done at 68.
    function automatic logic [7:0] exp_a(input int e);
        logic [3:0] r;
        logic [1:0] act;
        r   = {e >= 67, e >= 50, e >= 33, e >= 16};
        act = (e < 17) ? 2'd0 : (e < 34) ? 2'd1 : (e < 51) ? 2'd2 : 2'd3;
        return {r, act, e >= 68, 1'b0};
    endfunction

    // HOLD=4 with all acks high, k edges after reset release or restart request.
    function automatic logic [7:0] exp_b_seq(input int k);
        logic [3:0] r;
        logic [1:0] act;
        r   = {k >= 19, k >= 14, k >= 9, k >= 4};
        act = (k < 5) ? 2'd0 : (k < 10) ? 2'd1 : (k < 15) ? 2'd2 : 2'd3;
        return {r, act, k >= 20, 1'b0};
    endfunction

    // HOLD=4, TIMEOUT=8, stage 0 never acks: released at edge 4, error at edge 12.
    function automatic logic [7:0] exp_b_tmo(input int e);
        return {3'b000, (e >= 4) && (e < 12), 2'b00, 1'b0, e >= 12};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs);
        logic [7:0] exp;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $error("FAIL %s: observed=%b expected=<empty queue>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            n_vec++;
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
            end
        end
    endtask

    task automatic edge_b(input string tag, input logic [7:0] exp);
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check(tag, obs_b);
    endtask

    initial begin
        n_vec   = 0;
        n_fail  = 0;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        req_a   = 1'b0;
        req_b   = 1'b0;
        done_a  = 4'hF;
        done_b  = 4'h0;
        repeat (2) @(posedge clk);
        #1;

        exp_q.push_back(8'h00);
        check("reset_a", obs_a);
        exp_q.push_back(8'h00);
        check("reset_b", obs_b);

        // Sequence on A with acks high; timeout on B with no acks.
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        for (int e = 1; e <= 72; e++) begin
            exp_q.push_back(exp_a(e));
            if (e <= 40) exp_q.push_back(exp_b_tmo(e));
        end
        for (int e = 1; e <= 72; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("seq_a_e%0d", e), obs_a);
            if (e <= 40) check($sformatf("tmo_b_e%0d", e), obs_b);
        end

        // Restart B out of the error state with all acks present.
        done_b = 4'hF;
        req_b  = 1'b1;
        edge_b("sw_req_from_err", exp_b_seq(0));
        req_b = 1'b0;
        for (int k = 1; k <= 24; k++) edge_b($sformatf("restart_k%0d", k), exp_b_seq(k));

        // Only stage 1 acks: stage 0 must still time out, stage 1 never released early.
        rst_b_n = 1'b0;
        done_b  = 4'b0010;
        #1;
        exp_q.push_back(8'h00);
        check("async_from_done_b", obs_b);
        @(posedge clk);
        #1;
        rst_b_n = 1'b1;
        for (int e = 1; e <= 14; e++) edge_b($sformatf("wrong_ack_e%0d", e), exp_b_tmo(e));

        // Restart request lands on the edge that would release stage 2.
        rst_b_n = 1'b0;
        done_b  = 4'hF;
        @(posedge clk);
        #1;
        rst_b_n = 1'b1;
        for (int e = 1; e <= 13; e++) edge_b($sformatf("pre_req_e%0d", e), exp_b_seq(e));
        req_b = 1'b1;
        edge_b("req_vs_release", exp_b_seq(0));
        req_b = 1'b0;
        for (int k = 1; k <= 21; k++) edge_b($sformatf("post_req_k%0d", k), exp_b_seq(k));

        // A stalls waiting on stage 2, then async reset lands between edges.
        rst_a_n = 1'b0;
        done_a  = 4'b0011;
        @(posedge clk);
        #1;
        rst_a_n = 1'b1;
        for (int e = 1; e <= 55; e++) begin
            exp_q.push_back((e <= 50) ? exp_a(e) : {4'b0111, 2'd2, 1'b0, 1'b0});
            @(posedge clk);
            #1;
            check($sformatf("stall_a_e%0d", e), obs_a);
        end
        #2;
        rst_a_n = 1'b0;
        #1;
        exp_q.push_back(8'h00);
        check("async_mid_wait", obs_a);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
